div_clk_monitor: RTL and testbench
==================================

Name: div_clk_monitor

Overview:
- Sits directly downstream of the even clock divider. Samples the divider's three divided outputs (/2, /4, /8) in the clk_in domain.
- Per channel, it:
  - verifies the half-period of each output,
  - tracks lock and flags faults,
  - emits single-cycle rising-edge strobes that downstream logic uses as clock enables.
- Also checks that the three outputs are phase-aligned.

Parameters:
- LOCK_EDGES, 4: consecutive correct half-periods required before a channel is declared locked (1..15).
- CNT_W, 4: width of each half-period counter. Must satisfy 2^CNT_W > 8. The counter saturates at all-ones.

Ports:
- clk_in  input  1  sole clock, same clock that drives the divider.
- rst  input  1  synchronous, active-high reset.
- div_in  input  3  divided clocks: bit0=/2, bit1=/4, bit2=/8. Synchronous to clk_in.
- err_clr  input  1  clears err and phase_err; returns ERR channels to WAIT.
- rise_pulse  output  3  one-cycle strobe per channel on a 0->1 transition of div_in[k].
- locked  output  3  channel k is in LOCKED state.
- all_locked  output  1  AND of locked[2:0].
- err  output  3  sticky per-channel fault flag.
- phase_err  output  1  sticky misalignment flag.

Behaviour:
- Reset (rst=1 at a clk_in edge), applied in that cycle:
  - prev register cleared to 0, prime flag cleared;
  - all channels to WAIT, all counters 0;
  - all outputs 0.
- Reset mid-operation has the same effect; there is no partial state retention.
- Priming: the first cycle after reset only loads prev<=div_in and sets prime. Edge detection is enabled only while prime=1.
- Edge detection:
  - edge[k] = prime & (div_in[k] != prev[k]);
  - rise[k] = edge[k] & div_in[k];
  - prev <= div_in every cycle.
- Half-period counter hp[k]:
  - on edge[k], hp <= 0;
  - otherwise hp <= hp+1, saturating at 2^CNT_W-1.
  - Measured half-period at an edge is hp+1, using the pre-update value.
- Expected half-period H[k] = 1, 2, 4 for k = 0, 1, 2.
- good[k] = edge[k] & (hp+1 == H[k]).
- bad[k] is either of:
  - edge[k] & (hp+1 != H[k]);
  - no edge[k] & (hp == H[k]-1), i.e. a missed edge detected in the cycle it was due.
- Per-channel FSM; good_cnt is CNT_W bits:
  - WAIT: on the first edge[k] -> ACQ, good_cnt<=0. No checking in WAIT.
  - ACQ:
    - good -> good_cnt+1; when good_cnt+1 == LOCK_EDGES -> LOCKED;
    - bad -> good_cnt<=0, remain in ACQ (err not set).
  - LOCKED: good -> stay; bad -> ERR, err[k]<=1.
  - ERR: hold until err_clr -> WAIT, hp<=0.
- locked[k] = (state==LOCKED). It is registered and reflects the state after the update, so it drops in the cycle after the bad event.
- err_clr behaviour:
  - clears err and phase_err;
  - moves every ERR channel to WAIT;
  - does not affect channels in WAIT, ACQ or LOCKED.
  - If err_clr coincides with a bad event in LOCKED, that event still moves the channel to ERR, but err[k] stays 0 for that cycle's update (clr wins for the flags). The channel then sits in ERR with err[k]=0 until the next err_clr.
- Phase check: evaluated only while all_locked=1. When rise[2]=1, rise[0] and rise[1] must both be 1 in the same cycle; otherwise phase_err<=1 (sticky). A phase error does not change channel FSMs.
- rise_pulse <= rise. This is registered with 1 cycle latency after the div_in transition and is asserted regardless of FSM state once primed.
- Simultaneous error events on several channels are each flagged independently in the same cycle.

Test Plan:
- Nominal: drive div_in = ~cnt from a 3-bit up counter (reset value 7, wrapping), release rst at cycle 0, LOCK_EDGES=4 -> locked=3'b111 and all_locked=1 by cycle 30; err=0 and phase_err=0 over the following 200 cycles; rise_pulse[2] period 8, rise_pulse[0] period 2.
- Stuck fault: after all_locked, hold div_in[1] at 1 for 6 cycles -> err[1]=1 and locked[1]=0 one cycle after the missed-edge cycle; err[0]=err[2]=0; all_locked=0.
- Recovery: after the stuck fault, release div_in[1] and pulse err_clr for 1 cycle -> err=0, channel 1 re-enters WAIT/ACQ, locked[1]=1 again within 4*(LOCK_EDGES+2) cycles.
- Phase fault: while locked, hold the /2 and /4 stimulus for one clk_in cycle, then continue it while /8 keeps running -> phase_err=1, and err[0] and/or err[1] set; phase_err stays 1 until err_clr.
- Coincidence: assert err_clr in the same cycle as a bad event on locked channel 2 -> channel 2 enters ERR, err[2] reads 0 after that cycle; a second err_clr returns it to WAIT.
- Reset mid-lock: assert rst for 1 cycle at cycle 50 -> next cycle all outputs 0, no rise_pulse in the priming cycle, relock by cycle 80.

Source files
------------

// File: rtl/div_clk_monitor.sv
// div_clk_monitor: watches the /2, /4, /8 outputs of the even clock divider in
// the clk_in domain. For each channel it checks the half-period, tracks lock,
// flags faults and emits a one-cycle rising-edge strobe. It also checks that
// the three outputs rise together while every channel is locked.
//
// Ports:
//   clk_in      sole clock (same clock that drives the divider)
//   rst         synchronous active-high reset
//   div_in[2:0] divided clocks: bit0=/2, bit1=/4, bit2=/8
//   err_clr     clears err/phase_err and returns ERR channels to WAIT
//   rise_pulse  registered one-cycle strobe on a 0->1 transition of div_in[k]
//   locked      channel k is in LOCKED
//   all_locked  AND of locked
//   err         sticky per-channel fault flag
//   phase_err   sticky misalignment flag
module div_clk_monitor #(
  parameter int unsigned LOCK_EDGES = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic [2:0] div_in,
  input  logic       err_clr,
  output logic [2:0] rise_pulse,
  output logic [2:0] locked,
  output logic       all_locked,
  output logic [2:0] err,
  output logic       phase_err
);

  localparam int unsigned NCH = 3;
  localparam int unsigned MW  = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_ACQ,
    ST_LOCKED,
    ST_ERR
  } state_t;

  state_t           state_q [NCH];
  state_t           state_d [NCH];
  logic [CNT_W-1:0] hp_q    [NCH];
  logic [CNT_W-1:0] hp_d    [NCH];
  logic [CNT_W-1:0] gcnt_q  [NCH];
  logic [CNT_W-1:0] gcnt_d  [NCH];
  logic [MW-1:0]    meas_c  [NCH];

  logic           prime_q;
  logic [NCH-1:0] prev_q;
  logic [NCH-1:0] edg_c;
  logic [NCH-1:0] rise_c;
  logic [NCH-1:0] good_c;
  logic [NCH-1:0] bad_c;
  logic [NCH-1:0] err_d;
  logic [NCH-1:0] locked_d;
  logic           all_locked_d;
  logic           phase_err_d;

  // Expected half-period in clk_in cycles: 1, 2, 4 for /2, /4, /8.
  function automatic logic [MW-1:0] exp_half(input int k);
    return MW'(1) << k;
  endfunction

  // State register; reset clears every register with no retention.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      prime_q    <= 1'b0;
      prev_q     <= '0;
      rise_pulse <= '0;
      locked     <= '0;
      all_locked <= 1'b0;
      err        <= '0;
      phase_err  <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        state_q[k] <= ST_WAIT;
        hp_q[k]    <= '0;
        gcnt_q[k]  <= '0;
      end
    end else begin
      prime_q    <= 1'b1;
      prev_q     <= div_in;
      rise_pulse <= rise_c;
      locked     <= locked_d;
      all_locked <= all_locked_d;
      err        <= err_d;
      phase_err  <= phase_err_d;
      for (int k = 0; k < NCH; k++) begin
        state_q[k] <= state_d[k];
        hp_q[k]    <= hp_d[k];
        gcnt_q[k]  <= gcnt_d[k];
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    edg_c        = prime_q ? (div_in ^ prev_q) : '0;
    rise_c       = edg_c & div_in;
    good_c       = '0;
    bad_c        = '0;
    err_d        = err;
    locked_d     = '0;
    all_locked_d = 1'b0;
    phase_err_d  = phase_err;

    for (int k = 0; k < NCH; k++) begin
      state_d[k] = state_q[k];
      hp_d[k]    = hp_q[k];
      gcnt_d[k]  = gcnt_q[k];
      // Measured half-period uses the pre-update counter.
      meas_c[k]  = {1'b0, hp_q[k]} + MW'(1);

      good_c[k] = edg_c[k] & (meas_c[k] == exp_half(k));
      // Missed edge is caught in the very cycle the edge was due.
      bad_c[k]  = (edg_c[k] & (meas_c[k] != exp_half(k))) |
                  (~edg_c[k] & ({1'b0, hp_q[k]} == exp_half(k) - MW'(1)));

      if (edg_c[k]) begin
        hp_d[k] = '0;
      end else if (hp_q[k] != '1) begin
        hp_d[k] = hp_q[k] + CNT_W'(1);
      end

      unique case (state_q[k])
        ST_WAIT: begin
          if (edg_c[k]) begin
            state_d[k] = ST_ACQ;
            gcnt_d[k]  = '0;
          end
        end
        ST_ACQ: begin
          if (good_c[k]) begin
            gcnt_d[k] = gcnt_q[k] + CNT_W'(1);
            if (gcnt_q[k] + CNT_W'(1) == CNT_W'(LOCK_EDGES)) begin
              state_d[k] = ST_LOCKED;
            end
          end else if (bad_c[k]) begin
            gcnt_d[k] = '0;
          end
        end
        ST_LOCKED: begin
          if (bad_c[k]) begin
            state_d[k] = ST_ERR;
            err_d[k]   = 1'b1;
          end
        end
        ST_ERR: begin
          if (err_clr) begin
            state_d[k] = ST_WAIT;
            hp_d[k]    = '0;
          end
        end
        default: state_d[k] = ST_WAIT;
      endcase

      locked_d[k] = (state_d[k] == ST_LOCKED);
    end

    all_locked_d = &locked_d;

    // Phase check runs off the current (registered) lock status.
    if (all_locked && rise_c[2] && !(rise_c[0] && rise_c[1])) begin
      phase_err_d = 1'b1;
    end

    // Clear wins over any flag set in the same cycle.
    if (err_clr) begin
      err_d       = '0;
      phase_err_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Self-checking bench for div_clk_monitor. A time-stamp based reference model
// (cycle of last edge per channel) predicts every output each cycle.
module tb_div_clk_monitor;

  localparam int LOCK_EDGES = 4;
  localparam int CNT_W      = 4;
  localparam int S_WAIT = 0, S_ACQ = 1, S_LOCKED = 2, S_ERR = 3;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] div_in = '0;
  logic       err_clr = 1'b0;
  logic [2:0] rise_pulse, locked, err;
  logic       all_locked, phase_err;

  div_clk_monitor #(.LOCK_EDGES(LOCK_EDGES), .CNT_W(CNT_W)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .div_in    (div_in),
    .err_clr   (err_clr),
    .rise_pulse(rise_pulse),
    .locked    (locked),
    .all_locked(all_locked),
    .err       (err),
    .phase_err (phase_err)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_fail = 0;

  // Stimulus source: div_in = ~cnt, with an optional lag applied to /2 and /4.
  logic [2:0] cnt = 3'd7;
  logic [2:0] lag = 3'd0;

  // Reference model state.
  int         m_cyc = 0;
  logic       m_prime = 1'b0;
  logic [2:0] m_prev = '0;
  int         m_last [3];
  int         m_st   [3];
  int         m_gc   [3];
  logic [2:0] m_rise = '0, m_locked = '0, m_err = '0;
  logic       m_all = 1'b0, m_perr = 1'b0;

  logic [10:0] obs, exp_b;
  assign obs   = {rise_pulse, locked, all_locked, err, phase_err};
  assign exp_b = {m_rise, m_locked, m_all, m_err, m_perr};

  function automatic logic [2:0] stim();
    logic [2:0] lo;
    lo = cnt - lag;
    return {~cnt[2], ~lo[1:0]};
  endfunction

  task automatic model_step(input logic [2:0] d, input logic r, input logic c);
    logic [2:0] edg, rise, lk;
    int age, h, meas;
    bit good, bad, pe;
    m_cyc++;
    if (r) begin
      m_prime = 1'b0; m_prev = '0;
      for (int k = 0; k < 3; k++) begin
        m_st[k] = S_WAIT; m_gc[k] = 0; m_last[k] = m_cyc;
      end
      m_rise = '0; m_locked = '0; m_all = 1'b0; m_err = '0; m_perr = 1'b0;
    end else begin
      edg  = m_prime ? (d ^ m_prev) : 3'b000;
      rise = edg & d;
      pe   = m_all && rise[2] && !(rise[0] && rise[1]);
      for (int k = 0; k < 3; k++) begin
        h    = 1 << k;
        age  = m_cyc - m_last[k];
        meas = (age > 16) ? 16 : age;
        good = edg[k] && (meas == h);
        bad  = edg[k] ? (meas != h) : (age == h);
        if (edg[k]) m_last[k] = m_cyc;
        case (m_st[k])
          S_WAIT: if (edg[k]) begin m_st[k] = S_ACQ; m_gc[k] = 0; end
          S_ACQ: begin
            if (good) begin
              m_gc[k]++;
              if (m_gc[k] == LOCK_EDGES) m_st[k] = S_LOCKED;
            end else if (bad) m_gc[k] = 0;
          end
          S_LOCKED: if (bad) begin m_st[k] = S_ERR; m_err[k] = 1'b1; end
          default: if (c) begin m_st[k] = S_WAIT; m_last[k] = m_cyc; end
        endcase
        if (c) m_err[k] = 1'b0;
        lk[k] = (m_st[k] == S_LOCKED);
      end
      m_perr   = c ? 1'b0 : (m_perr | pe);
      m_rise   = rise;
      m_locked = lk;
      m_all    = &lk;
      m_prev   = d;
      m_prime  = 1'b1;
    end
  endtask

  // One clk_in cycle: drive, let the DUT and model advance, settle at negedge.
  task automatic tick(input logic [2:0] d, input logic r, input logic c);
    div_in = d; rst = r; err_clr = c;
    @(posedge clk_in);
    model_step(d, r, c);
    if (r) cnt = 3'd7; else cnt = cnt + 3'd1;
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) tick(3'($urandom_range(0, 7)), 1'b1, 1'b0);
    n_cmp++;
    if (obs !== 11'd0) begin
      n_fail++; $display("FAIL reset_zero got=%b want=%b", obs, 11'd0);
    end
    n_cmp++;
    if (obs !== exp_b) begin
      n_fail++; $display("FAIL reset_model got=%b want=%b", obs, exp_b);
    end
  endtask

  task automatic test_nominal();
    int last2, last0;
    last2 = -1; last0 = -1;
    for (int i = 0; i < 30; i++) begin
      tick(stim(), 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_b) begin
        n_fail++; $display("FAIL nominal_acq cyc=%0d got=%b want=%b", m_cyc, obs, exp_b);
      end
    end
    n_cmp++;
    if (locked !== 3'b111 || all_locked !== 1'b1) begin
      n_fail++; $display("FAIL nominal_lock got=%b/%b want=111/1", locked, all_locked);
    end
    for (int i = 0; i < 200; i++) begin
      tick(stim(), 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_b) begin
        n_fail++; $display("FAIL nominal_run cyc=%0d got=%b want=%b", m_cyc, obs, exp_b);
      end
      if (rise_pulse[2]) begin
        if (last2 >= 0) begin
          n_cmp++;
          if (i - last2 != 8) begin
            n_fail++; $display("FAIL period2 got=%0d want=8", i - last2);
          end
        end
        last2 = i;
      end
      if (rise_pulse[0]) begin
        if (last0 >= 0) begin
          n_cmp++;
          if (i - last0 != 2) begin
            n_fail++; $display("FAIL period0 got=%0d want=2", i - last0);
          end
        end
        last0 = i;
      end
    end
    n_cmp++;
    if (err !== 3'b000 || phase_err !== 1'b0) begin
      n_fail++; $display("FAIL nominal_clean got=%b/%b want=000/0", err, phase_err);
    end
  endtask

  task automatic test_stuck();
    for (int i = 0; i < 6; i++) begin
      tick(stim() | 3'b010, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_b) begin
        n_fail++; $display("FAIL stuck_run cyc=%0d got=%b want=%b", m_cyc, obs, exp_b);
      end
    end
    n_cmp++;
    if (err !== 3'b010 || locked !== 3'b101 || all_locked !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_flags got err=%b lk=%b all=%b want err=010 lk=101 all=0",
               err, locked, all_locked);
    end
  endtask

  task automatic test_recovery();
    tick(stim(), 1'b0, 1'b1);
    n_cmp++;
    if (err !== 3'b000 || phase_err !== 1'b0) begin
      n_fail++; $display("FAIL recov_clr got=%b/%b want=000/0", err, phase_err);
    end
    for (int i = 0; i < 4 * (LOCK_EDGES + 2); i++) begin
      tick(stim(), 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_b) begin
        n_fail++; $display("FAIL recov_run cyc=%0d got=%b want=%b", m_cyc, obs, exp_b);
      end
    end
    n_cmp++;
    if (locked !== 3'b111) begin
      n_fail++; $display("FAIL recov_lock got=%b want=111", locked);
    end
  endtask

  task automatic test_coincidence();
    tick(stim() ^ 3'b100, 1'b0, 1'b1);
    n_cmp++;
    if (err[2] !== 1'b0 || locked[2] !== 1'b0) begin
      n_fail++; $display("FAIL coinc_cycle got err2=%b lk2=%b want 0/0", err[2], locked[2]);
    end
    for (int i = 0; i < 3; i++) begin
      tick(stim(), 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_b) begin
        n_fail++; $display("FAIL coinc_hold cyc=%0d got=%b want=%b", m_cyc, obs, exp_b);
      end
    end
    n_cmp++;
    if (err[2] !== 1'b0 || locked[2] !== 1'b0 || locked[1:0] !== 2'b11) begin
      n_fail++; $display("FAIL coinc_err_state got err=%b lk=%b want 0xx/011", err, locked);
    end
    tick(stim(), 1'b0, 1'b1);
    for (int i = 0; i < 4 * (LOCK_EDGES + 2); i++) begin
      tick(stim(), 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_b) begin
        n_fail++; $display("FAIL coinc_relock cyc=%0d got=%b want=%b", m_cyc, obs, exp_b);
      end
    end
    n_cmp++;
    if (locked !== 3'b111 || err !== 3'b000) begin
      n_fail++; $display("FAIL coinc_final got lk=%b err=%b want 111/000", locked, err);
    end
  endtask

  task automatic test_phase();
    // Run up to the cycle where /8 rises, then stall /2 and /4 by one cycle.
    for (int i = 0; i < 8 && cnt != 3'd0; i++) tick(stim(), 1'b0, 1'b0);
    lag = 3'd1;
    for (int i = 0; i < 10; i++) begin
      tick(stim(), 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_b) begin
        n_fail++; $display("FAIL phase_run cyc=%0d got=%b want=%b", m_cyc, obs, exp_b);
      end
    end
    n_cmp++;
    if (phase_err !== 1'b1 || (err[0] | err[1]) !== 1'b1) begin
      n_fail++; $display("FAIL phase_flag got perr=%b err=%b want 1/err0|err1", phase_err, err);
    end
    for (int i = 0; i < 10; i++) tick(stim(), 1'b0, 1'b0);
    n_cmp++;
    if (phase_err !== 1'b1) begin
      n_fail++; $display("FAIL phase_sticky got=%b want=1", phase_err);
    end
    tick(stim(), 1'b0, 1'b1);
    n_cmp++;
    if (phase_err !== 1'b0 || obs !== exp_b) begin
      n_fail++; $display("FAIL phase_clr got=%b want=%b", obs, exp_b);
    end
  endtask

  task automatic test_reset_midlock();
    lag = 3'd0;
    tick(stim(), 1'b1, 1'b0);
    n_cmp++;
    if (obs !== 11'd0) begin
      n_fail++; $display("FAIL midrst_zero got=%b want=%b", obs, 11'd0);
    end
    tick(stim(), 1'b0, 1'b0);
    n_cmp++;
    if (rise_pulse !== 3'b000) begin
      n_fail++; $display("FAIL midrst_prime got=%b want=000", rise_pulse);
    end
    for (int i = 0; i < 29; i++) begin
      tick(stim(), 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_b) begin
        n_fail++; $display("FAIL midrst_run cyc=%0d got=%b want=%b", m_cyc, obs, exp_b);
      end
    end
    n_cmp++;
    if (locked !== 3'b111 || all_locked !== 1'b1) begin
      n_fail++; $display("FAIL midrst_relock got=%b/%b want=111/1", locked, all_locked);
    end
  endtask

  task automatic test_random();
    logic [2:0] d;
    logic r, c;
    for (int i = 0; i < 600; i++) begin
      d = stim();
      if ($urandom_range(0, 24) == 0) d = d ^ 3'(1 << $urandom_range(0, 2));
      c = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 299) == 0);
      tick(d, r, c);
      n_cmp++;
      if (obs !== exp_b) begin
        n_fail++; $display("FAIL random cyc=%0d got=%b want=%b", m_cyc, obs, exp_b);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_last[k] = 0; m_st[k] = S_WAIT; m_gc[k] = 0;
    end
    @(negedge clk_in);
    test_reset();
    test_nominal();
    test_stuck();
    test_recovery();
    test_coincidence();
    test_phase();
    test_reset_midlock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
